decode_lsps_scalar: RTL

//  Inverse of the scalar LSP encoder in the codec2 2400 chain. Takes ten 4-bit codebook

---
 rtl/decode_lsps_scalar.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/decode_lsps_scalar.sv
// Scalar LSP decoder: codebook index -> ROM lookup (Hz, Q16) -> radians, ten writes to LSP RAM.
// Optional LSP_ORDER_CHECK_EN enforces a minimum spacing between successive LSPs.
module decode_lsps_scalar #(
  parameter int N = 32,
  parameter int Q = 16,
  parameter logic [N-1:0] HZTORAD = 32'h00000033
`ifdef LSP_ORDER_CHECK_EN
  , parameter logic [N-1:0] MIN_SEP = 32'h0000028F
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_dlsp,
  input  logic [3:0]   indexes0,
  input  logic [3:0]   indexes1,
  input  logic [3:0]   indexes2,
  input  logic [3:0]   indexes3,
  input  logic [3:0]   indexes4,
  input  logic [3:0]   indexes5,
  input  logic [3:0]   indexes6,
  input  logic [3:0]   indexes7,
  input  logic [3:0]   indexes8,
  input  logic [3:0]   indexes9,
  output logic [7:0]   cb_addr,
  input  logic [N-1:0] cb_data,
  output logic [3:0]   addr_lsp,
  output logic [N-1:0] lsp_in,
  output logic         we_lsp,
  output logic         done_dlsp
);

  typedef enum logic [3:0] {
    S_START, S_LATCH_IDX, S_INIT_FOR, S_CHECK_FOR_I, S_SET_ADDR, S_SET_DELAY1,
    S_SET_DELAY2, S_CONVERT, S_WRITE_LSP, S_INCR_FOR_I, S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     i_q, i_d;
  logic [3:0]     idx_q [10];
  logic [3:0]     idx_d [10];
  logic [7:0]     cb_addr_q, cb_addr_d;
  logic [3:0]     addr_lsp_q, addr_lsp_d;
  logic [N-1:0]   lsp_q, lsp_d;
  logic [N-1:0]   rad_q, rad_d;
  logic           we_q, we_d;
  logic           done_q, done_d;
  logic signed [2*N-1:0] prod;
  logic [N-1:0]   rad_calc;
`ifdef LSP_ORDER_CHECK_EN
  logic [N-1:0]   prev_q, prev_d;
  logic [N-1:0]   rad_floor;
`endif

  // Tail codebooks are smaller: 8 entries for LSPs 7..8, 4 entries for LSP 9.
  function automatic logic [3:0] clamp_idx(input logic [3:0] i, input logic [3:0] v);
    if (i < 4'd7)      return v;
    else if (i < 4'd9) return (v > 4'd7) ? 4'd7 : v;
    else               return (v > 4'd3) ? 4'd3 : v;
  endfunction

  always_comb begin
    prod     = $signed({{N{cb_data[N-1]}}, cb_data}) * $signed({{N{HZTORAD[N-1]}}, HZTORAD});
    rad_calc = N'(prod >>> Q);
`ifdef LSP_ORDER_CHECK_EN
    rad_floor = prev_q + MIN_SEP;
    if ((i_q != 4'd0) && ($signed(rad_calc) < $signed(rad_floor)))
      rad_calc = rad_floor;
`endif
  end

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    idx_d      = idx_q;
    cb_addr_d  = cb_addr_q;
    addr_lsp_d = addr_lsp_q;
    lsp_d      = lsp_q;
    rad_d      = rad_q;
    we_d       = we_q;
    done_d     = done_q;
`ifdef LSP_ORDER_CHECK_EN
    prev_d     = prev_q;
`endif
    unique case (state_q)
      S_START: begin
        done_d = 1'b0;
        we_d   = 1'b0;
        if (start_dlsp) state_d = S_LATCH_IDX;
      end
      S_LATCH_IDX: begin
        idx_d[0] = indexes0; idx_d[1] = indexes1; idx_d[2] = indexes2;
        idx_d[3] = indexes3; idx_d[4] = indexes4; idx_d[5] = indexes5;
        idx_d[6] = indexes6; idx_d[7] = indexes7; idx_d[8] = indexes8;
        idx_d[9] = indexes9;
        state_d  = S_INIT_FOR;
      end
      S_INIT_FOR: begin
        i_d     = '0;
        state_d = S_CHECK_FOR_I;
      end
      S_CHECK_FOR_I: state_d = (i_q >= 4'd10) ? S_DONE : S_SET_ADDR;
      S_SET_ADDR: begin
        cb_addr_d  = {i_q, clamp_idx(i_q, idx_q[i_q])};
        addr_lsp_d = i_q;
        state_d    = S_SET_DELAY1;
      end
      S_SET_DELAY1: state_d = S_SET_DELAY2;
      S_SET_DELAY2: state_d = S_CONVERT;
      S_CONVERT: begin
        rad_d   = rad_calc;
`ifdef LSP_ORDER_CHECK_EN
        prev_d  = rad_calc;
`endif
        state_d = S_WRITE_LSP;
      end
      S_WRITE_LSP: begin
        lsp_d   = rad_q;
        we_d    = 1'b1;
        state_d = S_INCR_FOR_I;
      end
      S_INCR_FOR_I: begin
        we_d    = 1'b0;
        i_d     = i_q + 4'd1;
        state_d = S_CHECK_FOR_I;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_START;
      end
      default: state_d = S_START;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_START;
      i_q        <= '0;
      idx_q      <= '{default: '0};
      cb_addr_q  <= '0;
      addr_lsp_q <= '0;
      lsp_q      <= '0;
      rad_q      <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
`ifdef LSP_ORDER_CHECK_EN
      prev_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      idx_q      <= idx_d;
      cb_addr_q  <= cb_addr_d;
      addr_lsp_q <= addr_lsp_d;
      lsp_q      <= lsp_d;
      rad_q      <= rad_d;
      we_q       <= we_d;
      done_q     <= done_d;
`ifdef LSP_ORDER_CHECK_EN
      prev_q     <= prev_d;
`endif
    end
  end

  assign cb_addr   = cb_addr_q;
  assign addr_lsp  = addr_lsp_q;
  assign lsp_in    = lsp_q;
  assign we_lsp    = we_q;
  assign done_dlsp = done_q;

endmodule
